instruction_fetch: RTL

- Fetch stage directly upstream of InstructionMemory. Holds the program counter and drives the memory's `Address` port.
- Samples the memory's combinational `Instruction` output into an IF/ID register.
- Presents the registered instruction to decode through a valid/ready handshake.
- Handles stall, branch/jump redirect with flush, and halt.

---
 rtl/instruction_fetch_pkg.sv | 17 +
 rtl/instruction_fetch_pipe_reg.sv | 54 +++++
 rtl/instruction_fetch.sv | 125 ++++++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage types and defaults, also imported by InstructionMemory and decode.
// Holds the 1-bit FSM encoding, default widths and a saturating counter helper.
package instruction_fetch_pkg;

  localparam int unsigned L_DEFAULT            = 16;
  localparam int unsigned RESET_VECTOR_DEFAULT = 0;

  typedef enum logic {
    FETCH_S  = 1'b0,
    HALTED_S = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/instruction_fetch_pipe_reg.sv
// IF/ID register: one-cycle capture of instruction and PC, with flush, consume and hold.
// Backpressure: holds its contents whenever no load, flush or consume is requested.
module fetch_pipe_reg #(
  parameter int unsigned L = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         flush,
  input  logic         consume,
  input  logic [L-1:0] in_instr,
  input  logic [L-1:0] in_pc,
  output logic         out_vld,
  output logic [L-1:0] out_instr_dat,
  output logic [L-1:0] out_pc_dat
);

  logic         vld_q,   vld_d;
  logic [L-1:0] instr_q, instr_d;
  logic [L-1:0] pc_q,    pc_d;

  // Flush wins over load so a redirect always discards the in-flight fetch.
  always_comb begin
    vld_d   = vld_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush) begin
      vld_d = 1'b0;
    end else if (load) begin
      vld_d   = 1'b1;
      instr_d = in_instr;
      pc_d    = in_pc;
    end else if (consume) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      vld_q   <= vld_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign out_vld       = vld_q;
  assign out_instr_dat = instr_q;
  assign out_pc_dat    = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, FETCH/HALTED FSM and IF/ID register; one instruction per cycle, 1-bubble redirect.
// Stalls (PC and IF/ID hold) while OutValid && !OutReady; optional FETCH_PERF_COUNTERS_EN adds counters.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned  L            = L_DEFAULT,
  parameter logic [L-1:0] RESET_VECTOR = L'(RESET_VECTOR_DEFAULT),
  parameter logic [L-1:0] PC_STEP      = L'(1)
) (
  input  logic         Clock,
  input  logic         Reset,
  output logic [L-1:0] Address,
  input  logic [L-1:0] Instruction,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [L-1:0] OutInstruction,
  output logic [L-1:0] OutPC,
  input  logic         Redirect,
  input  logic [L-1:0] RedirectTarget,
  input  logic         Halt,
  output logic         Halted
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]  FetchCount,
  output logic [31:0]  StallCount
`endif
);

  fetch_state_e state_q, state_d;
  logic         halted_q, halted_d;
  logic [L-1:0] pc_q, pc_d;
  logic         take;
  logic         load;
  logic         flush;
  logic         consume;
  logic         out_vld;

  assign take = (state_q == FETCH_S) && (!out_vld || OutReady);

  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    pc_d     = pc_q;
    load     = 1'b0;
    flush    = 1'b0;
    consume  = 1'b0;
    if (Redirect) begin
      pc_d     = RedirectTarget;
      flush    = 1'b1;
      state_d  = FETCH_S;
      halted_d = 1'b0;
    end else begin
      if (take) begin
        load = 1'b1;
      end else if (out_vld && OutReady) begin
        consume = 1'b1;
      end
      // A halting cycle still completes its fetch but leaves the PC parked.
      if (Halt) begin
        state_d  = HALTED_S;
        halted_d = 1'b1;
      end else if (take) begin
        pc_d = pc_q + PC_STEP;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= FETCH_S;
      halted_q <= 1'b0;
      pc_q     <= RESET_VECTOR;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      pc_q     <= pc_d;
    end
  end

  fetch_pipe_reg #(
    .L (L)
  ) u_pipe_reg (
    .clk           (Clock),
    .rst           (Reset),
    .load          (load),
    .flush         (flush),
    .consume       (consume),
    .in_instr      (Instruction),
    .in_pc         (pc_q),
    .out_vld       (out_vld),
    .out_instr_dat (OutInstruction),
    .out_pc_dat    (OutPC)
  );

  assign Address  = pc_q;
  assign OutValid = out_vld;
  assign Halted   = halted_q;

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    fetch_count_d = load ? sat_inc32(fetch_count_q) : fetch_count_q;
    stall_count_d = stall_count_q;
    if ((state_q == FETCH_S) && out_vld && !OutReady && !Redirect) begin
      stall_count_d = sat_inc32(stall_count_q);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign FetchCount = fetch_count_q;
  assign StallCount = stall_count_q;
`endif

endmodule
